vduty_frame_gen: RTL and testbench
==================================

Name: vduty_frame_gen

Overview:
- Generates the per-frame vertical-duty strobe oV_Duty from the incoming panel timing (VSYNC/DE) on the output dot clock.
- This strobe restarts the downstream output-unit-enable / algorithm-reset sequencer.
- Also measures active lines per frame and flags missing or short frames.
- A watchdog keeps strobes coming when VSYNC disappears, so the backlight algorithm never stalls.

Parameters:
- PULSE_W, 4: oV_Duty high time in iODCK cycles; legal range 1..15.
- TIMEOUT, 1048575: cycles without a VSYNC leading edge before the watchdog self-generates a strobe; must be > PULSE_W + 100.
- MIN_LINES, 16: minimum DE lines for a frame to count as valid.
- VS_POL, 1: iVSYNC active level (1 = active-high, 0 = active-low).
- LINE_W, 12: width of the line counter and of oLine_Cnt.

Ports:
- iODCK  in  1  output dot clock; all logic on its rising edge.
- iRST_N  in  1  asynchronous, active-low reset.
- iVSYNC  in  1  vertical sync, iODCK domain, polarity per VS_POL.
- iDE  in  1  data enable, iODCK domain, high during active pixels.
- oV_Duty  out  1  frame strobe, high for PULSE_W cycles.
- oLine_Cnt  out  LINE_W  DE lines counted in the previous frame.
- oFrame_Valid  out  1  previous frame had oLine_Cnt >= MIN_LINES.
- oFrame_Cnt  out  8  frame counter; increments on every strobe start; wraps 255->0.
- oTimeout  out  1  last strobe came from the watchdog; sticky until the next real VSYNC edge.

Behaviour:
Reset and state
- Reset is asynchronous on iRST_N low. All outputs, counters and registers go to 0.
- State goes to IDLE.
- The VSYNC and DE history registers reset to the inactive level.

Edge detection
- vs = iVSYNC XNOR VS_POL.
- vs_q and de_q are 1-cycle registered copies of vs and iDE.
- A VSYNC edge (vs_edge) is vs & ~vs_q, evaluated at a clock edge.
- A line (line_edge) is iDE & ~de_q.

State machine (IDLE, PULSE, WAIT)
- IDLE: no strobes. On vs_edge -> PULSE. On watchdog expiry -> PULSE with oTimeout=1.
- PULSE: oV_Duty=1 and the pulse counter increments. When the count reaches PULSE_W-1 -> WAIT.
- WAIT: oV_Duty=0. On vs_edge -> PULSE. On watchdog expiry -> PULSE.

Latency and strobe start
- vs sampled low at edge k-1 and high at edge k: oV_Duty rises after edge k and falls after edge k+PULSE_W.
- Exactly PULSE_W high cycles per strobe.
- On the strobe's first cycle:
  - oFrame_Cnt increments.
  - oLine_Cnt is loaded with the running line count.
  - oFrame_Valid = (running count >= MIN_LINES).
  - The running count is cleared to 0, or to 1 if line_edge is in the same cycle.
  - The watchdog counter is cleared.

Line counting
- Each line_edge outside a strobe-start cycle increments the running count.
- The running count saturates at all-ones; it never wraps.

Watchdog
- The counter increments every cycle in IDLE and WAIT.
- Expiry occurs when the count reaches TIMEOUT-1 with no vs_edge in that cycle.
- An expiry strobe sets oTimeout=1 and loads oFrame_Valid=0 (oLine_Cnt is still loaded).
- oTimeout clears only at the start of a strobe triggered by a real vs_edge.

Boundary cases
- vs_edge during PULSE is ignored: no retrigger, no count change.
- vs_edge in the same cycle as watchdog expiry: the real edge wins and oTimeout=0.
- DE active across a strobe start: the edge is counted in the new frame.
- VSYNC held active permanently: a single strobe, then the watchdog takes over.
- iRST_N asserted mid-strobe: oV_Duty drops immediately, asynchronously. After release the block is in IDLE and waits for a new edge; it does not resume the old pulse.

Optional Feature:
Macro VDUTY_GLITCH_FILTER_EN.
- Defined:
  - vs passes a 3-sample agreement filter before edge detection; the filtered level changes only after 3 consecutive equal samples.
  - VSYNC pulses shorter than 3 cycles produce no strobe.
  - Strobe latency grows by 2 cycles: oV_Duty rises after edge k+2 when raw vs is first high at edge k.
  - The filter resets to the inactive level.
- Undefined: no filter; latency as in Behaviour.

Test Plan:
1. Reset, then VSYNC high at cycle 10 (PULSE_W=4) -> oV_Duty high for cycles 10..13 exactly; oFrame_Cnt=1; oTimeout=0.
2. Frame with 20 DE lines then VSYNC -> oLine_Cnt=20, oFrame_Valid=1. Next frame with 10 lines -> oLine_Cnt=10, oFrame_Valid=0.
3. TIMEOUT overridden to 200 and VSYNC stops -> self strobe 200 cycles after the last strobe start; oTimeout=1; repeats every 200 cycles. A real VSYNC then clears oTimeout.
4. Second VSYNC edge 2 cycles into a strobe -> no extension; strobe still 4 cycles; oFrame_Cnt +1 only.
5. iRST_N low on the 2nd strobe cycle -> oV_Duty 0 same cycle; all outputs 0; no strobe until the next VSYNC edge.
6. With VDUTY_GLITCH_FILTER_EN: 2-cycle VSYNC blip -> no strobe. 5-cycle VSYNC -> strobe rises 2 cycles later than without the macro.

Source files
------------

// File: rtl/vduty_frame_gen_if.sv
// Panel-timing in / frame-strobe out bundle for vduty_frame_gen.
// slave = the strobe generator, master = whatever drives VSYNC/DE and consumes the strobe.
interface vduty_frame_gen_if #(
  parameter int LINE_W = 12
);
  logic              iVSYNC;
  logic              iDE;
  logic              oV_Duty;
  logic [LINE_W-1:0] oLine_Cnt;
  logic              oFrame_Valid;
  logic [7:0]        oFrame_Cnt;
  logic              oTimeout;

  modport master (
    output iVSYNC, iDE,
    input  oV_Duty, oLine_Cnt, oFrame_Valid, oFrame_Cnt, oTimeout
  );

  modport slave (
    input  iVSYNC, iDE,
    output oV_Duty, oLine_Cnt, oFrame_Valid, oFrame_Cnt, oTimeout
  );
endinterface

// File: rtl/vduty_frame_gen.sv
// Per-frame vertical-duty strobe generator with line counting and a VSYNC watchdog.
// Optional VSYNC 3-sample glitch filter: define VDUTY_GLITCH_FILTER_EN.
module vduty_frame_gen #(
  parameter int PULSE_W   = 4,
  parameter int TIMEOUT   = 1048575,
  parameter int MIN_LINES = 16,
  parameter int VS_POL    = 1,
  parameter int LINE_W    = 12
) (
  input logic              iODCK,
  input logic              iRST_N,
  vduty_frame_gen_if.slave bus
);

  typedef enum logic [1:0] {IDLE, PULSE, WAIT} state_t;

  localparam int              WD_W    = $clog2(TIMEOUT + 1);
  localparam logic            VS_ACT  = (VS_POL != 0);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [3:0]      PC_LAST = 4'(PULSE_W - 1);
  localparam logic [31:0]     MIN_L   = 32'(MIN_LINES);

  state_t            stateQ, stateD;
  logic              vs, vsLvl, vsQ, deQ;
  logic              vsEdge, lineEdge, wdHit, startStrobe;
  logic [3:0]        pulseCnt;
  logic [WD_W-1:0]   wdCnt;
  logic [LINE_W-1:0] lineRun, lineOut;
  logic              frameValid, timeoutQ;
  logic [7:0]        frameCnt;

  // Normalise VSYNC so that 1 always means "active".
  assign vs = ~(bus.iVSYNC ^ VS_ACT);

`ifdef VDUTY_GLITCH_FILTER_EN
  logic [1:0] vsHist;

  always_ff @(posedge iODCK or negedge iRST_N) begin
    if (!iRST_N) vsHist <= 2'b00;
    else         vsHist <= {vsHist[0], vs};
  end

  // Filtered level only moves once three consecutive samples agree; vsQ holds it otherwise.
  always_comb begin
    vsLvl = vsQ;
    if (vs & vsHist[0] & vsHist[1])         vsLvl = 1'b1;
    else if (~(vs | vsHist[0] | vsHist[1])) vsLvl = 1'b0;
  end
`else
  assign vsLvl = vs;
`endif

  always_ff @(posedge iODCK or negedge iRST_N) begin
    if (!iRST_N) begin
      vsQ <= 1'b0;
      deQ <= 1'b0;
    end else begin
      vsQ <= vsLvl;
      deQ <= bus.iDE;
    end
  end

  assign vsEdge   = vsLvl & ~vsQ;
  assign lineEdge = bus.iDE & ~deQ;
  assign wdHit    = (wdCnt == WD_LAST);

  always_ff @(posedge iODCK or negedge iRST_N) begin
    if (!iRST_N) stateQ <= IDLE;
    else         stateQ <= stateD;
  end

  // A real edge and a watchdog hit in the same cycle both start a strobe; vsEdge decides oTimeout.
  always_comb begin
    stateD      = stateQ;
    startStrobe = 1'b0;
    case (stateQ)
      IDLE, WAIT: begin
        if (vsEdge || wdHit) begin
          stateD      = PULSE;
          startStrobe = 1'b1;
        end
      end
      PULSE:   if (pulseCnt == PC_LAST) stateD = WAIT;
      default: stateD = IDLE;
    endcase
  end

  always_ff @(posedge iODCK or negedge iRST_N) begin
    if (!iRST_N)              pulseCnt <= 4'd0;
    else if (startStrobe)     pulseCnt <= 4'd0;
    else if (stateQ == PULSE) pulseCnt <= pulseCnt + 4'd1;
  end

  // Watchdog runs from the last strobe start, so self-strobes repeat every TIMEOUT cycles.
  always_ff @(posedge iODCK or negedge iRST_N) begin
    if (!iRST_N)          wdCnt <= '0;
    else if (startStrobe) wdCnt <= '0;
    else if (!wdHit)      wdCnt <= wdCnt + WD_W'(1);
  end

  always_ff @(posedge iODCK or negedge iRST_N) begin
    if (!iRST_N) begin
      lineRun    <= '0;
      lineOut    <= '0;
      frameValid <= 1'b0;
      frameCnt   <= 8'd0;
      timeoutQ   <= 1'b0;
    end else if (startStrobe) begin
      lineOut    <= lineRun;
      frameValid <= vsEdge && (32'(lineRun) >= MIN_L);
      frameCnt   <= frameCnt + 8'd1;
      timeoutQ   <= ~vsEdge;
      lineRun    <= LINE_W'(lineEdge);
    end else if (lineEdge && (lineRun != {LINE_W{1'b1}})) begin
      lineRun    <= lineRun + LINE_W'(1);
    end
  end

  assign bus.oV_Duty      = (stateQ == PULSE);
  assign bus.oLine_Cnt    = lineOut;
  assign bus.oFrame_Valid = frameValid;
  assign bus.oFrame_Cnt   = frameCnt;
  assign bus.oTimeout     = timeoutQ;

endmodule

// File: tb/tb_vduty_frame_gen.sv
// Directed + randomized bench for vduty_frame_gen against a cycle-count reference model.
// A second instance with a 4-bit line counter exercises line-count saturation.
module tb_vduty_frame_gen;
  localparam int PW = 4;
  localparam int TO = 200;
  localparam int ML = 16;
  localparam int LW = 12;
  localparam int SW = 4;
`ifdef VDUTY_GLITCH_FILTER_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic iODCK  = 1'b0;
  logic iRST_N = 1'b0;
  logic vsync  = 1'b0;
  logic de     = 1'b0;
  always #5 iODCK = ~iODCK;

  vduty_frame_gen_if #(.LINE_W(LW)) bus ();
  vduty_frame_gen_if #(.LINE_W(SW)) busS ();
  assign bus.iVSYNC  = vsync;
  assign bus.iDE     = de;
  assign busS.iVSYNC = vsync;
  assign busS.iDE    = de;

  vduty_frame_gen #(.PULSE_W(PW), .TIMEOUT(TO), .MIN_LINES(ML), .VS_POL(1), .LINE_W(LW)) dut (
    .iODCK(iODCK), .iRST_N(iRST_N), .bus(bus.slave));
  vduty_frame_gen #(.PULSE_W(PW), .TIMEOUT(TO), .MIN_LINES(ML), .VS_POL(1), .LINE_W(SW)) dutS (
    .iODCK(iODCK), .iRST_N(iRST_N), .bus(busS.slave));

  int nCmp = 0;
  int nErr = 0;

  // Reference model state: everything is expressed as cycle ages and plain counts.
  int cyc, lastStart, running, frameCnt, lineOut, dutyHigh;
  bit started, valid, tmo, expDuty, fltLvl, h1, h2, prevDe;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    cyc = 0; lastStart = 0; started = 0; running = 0; frameCnt = 0; lineOut = 0;
    valid = 0; tmo = 0; expDuty = 0; fltLvl = 0; h1 = 0; h2 = 0; prevDe = 0;
  endtask

  task automatic modelEdge(input bit a, input bit d);
    bit lvl, realEdge, lineEdge, inPulse, expire, start;
    int age;
    cyc++;
    lvl = (LAT == 0) ? a : ((a == h1 && a == h2) ? a : fltLvl);
    h2 = h1; h1 = a;
    realEdge = lvl && !fltLvl;
    fltLvl = lvl;
    lineEdge = d && !prevDe;
    prevDe = d;
    age = cyc - lastStart;
    inPulse = started && age <= PW;
    expire = !inPulse && age == TO;
    start = !inPulse && (realEdge || expire);
    if (start) begin
      frameCnt  = (frameCnt + 1) % 256;
      lineOut   = running;
      valid     = realEdge && running >= ML;
      tmo       = !realEdge;
      running   = lineEdge ? 1 : 0;
      lastStart = cyc;
      started   = 1;
    end else if (lineEdge && running < (1 << LW) - 1) begin
      running++;
    end
    expDuty = started && (cyc - lastStart) < PW;
  endtask

  task automatic checkAll();
    chk("duty", bus.oV_Duty, expDuty);
    chk("lineCnt", bus.oLine_Cnt, lineOut);
    chk("frameValid", bus.oFrame_Valid, valid);
    chk("frameCnt", bus.oFrame_Cnt, frameCnt);
    chk("timeout", bus.oTimeout, tmo);
    chk("dutyS", busS.oV_Duty, expDuty);
    chk("lineCntSat", busS.oLine_Cnt, (lineOut > 15) ? 15 : lineOut);
    chk("frameValidS", busS.oFrame_Valid, 0);
  endtask

  task automatic resetChecks(input string tag);
    chk({tag, "_duty"}, bus.oV_Duty, 0);
    chk({tag, "_lineCnt"}, bus.oLine_Cnt, 0);
    chk({tag, "_valid"}, bus.oFrame_Valid, 0);
    chk({tag, "_frameCnt"}, bus.oFrame_Cnt, 0);
    chk({tag, "_timeout"}, bus.oTimeout, 0);
    chk({tag, "_dutyS"}, busS.oV_Duty, 0);
    chk({tag, "_lineCntS"}, busS.oLine_Cnt, 0);
  endtask

  task automatic tick(input bit v, input bit d);
    vsync = v;
    de    = d;
    @(posedge iODCK);
    modelEdge(v, d);
    #1;
    if (bus.oV_Duty === 1'b1) dutyHigh++;
    checkAll();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0);
  endtask

  task automatic lines(input int n);
    for (int l = 0; l < n; l++) begin
      for (int i = 0; i < int'($urandom_range(1, 4)); i++) tick(1'b0, 1'b1);
      for (int i = 0; i < int'($urandom_range(1, 3)); i++) tick(1'b0, 1'b0);
    end
  endtask

  task automatic vpulse(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  initial begin
    int fc, n, rise;
    modelReset();
    dutyHigh = 0;
    repeat (3) @(posedge iODCK);
    #1;
    resetChecks("reset");
    iRST_N = 1'b1;

    // VSYNC first active at cycle 10 after release
    idle(9);
    vpulse(6);
    idle(10);
    chk("t1_highCycles", dutyHigh, PW);
    chk("t1_frameCnt", bus.oFrame_Cnt, 1);
    chk("t1_timeout", bus.oTimeout, 0);

    // Line counting, valid and short frames
    lines(20); vpulse(5); idle(6);
    chk("t2_lines20", bus.oLine_Cnt, 20);
    chk("t2_valid20", bus.oFrame_Valid, 1);
    chk("t2_sat4bit", busS.oLine_Cnt, 15);
    lines(10); vpulse(5); idle(6);
    chk("t2_lines10", bus.oLine_Cnt, 10);
    chk("t2_valid10", bus.oFrame_Valid, 0);

    // DE rising on the strobe-start cycle lands in the new frame
    lines(3);
    for (int i = 0; i < 5; i++) tick(1'b1, i >= LAT);
    idle(5); vpulse(5); idle(6);
    chk("t7_deAcross", bus.oLine_Cnt, 1);

    // Watchdog self-strobes, then a real edge coinciding with expiry
    fc = frameCnt;
    idle(450);
    chk("t3_timeout", bus.oTimeout, 1);
    chk("t3_frames", bus.oFrame_Cnt, (fc + 2) % 256);
    chk("t3_validZero", bus.oFrame_Valid, 0);
    n = 0;
    while ((cyc - lastStart) != TO - LAT - 1 && n < 300) begin idle(1); n++; end
    chk("t3_alignBound", (n < 300), 1);
    fc = frameCnt;
    vpulse(5); idle(6);
    chk("t3_coincClear", bus.oTimeout, 0);
    chk("t3_coincFrames", bus.oFrame_Cnt, (fc + 1) % 256);

    // Second edge inside a strobe is ignored
    fc = frameCnt; dutyHigh = 0;
    tick(1, 0); tick(0, 0); tick(1, 0); tick(1, 0); tick(1, 0); tick(0, 0);
    idle(10);
    chk("t4_highCycles", dutyHigh, PW);
    chk("t4_frames", bus.oFrame_Cnt, (fc + 1) % 256);

    // Asynchronous reset on the second strobe cycle
    n = 0;
    while (bus.oV_Duty !== 1'b1 && n < 8) begin tick(1, 0); n++; end
    chk("t5_strobeSeen", bus.oV_Duty, 1);
    tick(1, 0);
    iRST_N = 1'b0;
    #1;
    resetChecks("t5_async");
    modelReset();
    vsync = 1'b0;
    repeat (2) @(posedge iODCK);
    #1;
    iRST_N = 1'b1;
    dutyHigh = 0;
    idle(20);
    chk("t5_noResume", dutyHigh, 0);
    vpulse(5); idle(6);
    chk("t5_restart", bus.oFrame_Cnt, 1);

    // Short VSYNC blip and strobe latency
    dutyHigh = 0;
    tick(1, 0); tick(1, 0); idle(10);
    chk("t6_blip", dutyHigh, (LAT == 0) ? PW : 0);
    rise = -1;
    for (int i = 0; i < 5; i++) begin
      tick(1, 0);
      if (bus.oV_Duty === 1'b1 && rise < 0) rise = i;
    end
    idle(6);
    chk("t6_latency", rise, LAT);

    // Randomized frames: line counts, DE across VSYNC, short VSYNC, watchdog gaps
    for (int f = 0; f < 25; f++) begin
      lines($urandom_range(0, 24));
      if ($urandom_range(0, 4) == 0) idle($urandom_range(150, 260));
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) tick(1'b1, 1'($urandom_range(0, 1)));
      idle($urandom_range(1, 8));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end
endmodule
